// File: rtl/div_seq.sv
// Iterative RV64M DIV/DIVU/REM/REMU (+W) sequencer, restoring division, one quotient bit per cycle.
// Latency: N+1 cycles after accept (N=32 word, XLEN full), specials ready at accept edge; result held in DONE until out_ready.
module div_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [1:0]      op,
  input  logic            word_op,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] res,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            neg_a_q, neg_a_d;
  logic            neg_b_q, neg_b_d;
  logic [XLEN-1:0] dvd_q, dvd_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            sgn, neg_a, neg_b, b_zero, ovf;
  logic [XLEN-1:0] a_w, b_w, a_sx, a_min, mag_a, mag_b, spec_res;
  logic [XLEN:0]   rem_sh, trial;
  logic [XLEN-1:0] q_raw, q_fix, r_fix, sel, fix_res;

  // Word operands are sign-extended only for signed ops so the magnitude logic is width-agnostic.
  assign sgn    = ~op[0];
  assign a_w    = word_op ? {{(XLEN-32){sgn & a[31]}}, a[31:0]} : a;
  assign b_w    = word_op ? {{(XLEN-32){sgn & b[31]}}, b[31:0]} : b;
  assign a_sx   = word_op ? {{(XLEN-32){a[31]}}, a[31:0]} : a;
  assign neg_a  = sgn & a_w[XLEN-1];
  assign neg_b  = sgn & b_w[XLEN-1];
  assign mag_a  = neg_a ? -a_w : a_w;
  assign mag_b  = neg_b ? -b_w : b_w;
  assign a_min  = word_op ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign b_zero = (b_w == '0);
  assign ovf    = sgn & (a_w == a_min) & (b_w == '1);
  assign spec_res = b_zero ? (op[1] ? a_sx : '1) : (op[1] ? '0 : a_sx);

  assign rem_sh = {rem_q, dvd_q[XLEN-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  assign q_raw   = word_q ? {{(XLEN-32){1'b0}}, dvd_q[31:0]} : dvd_q;
  assign q_fix   = (neg_a_q ^ neg_b_q) ? -q_raw : q_raw;
  assign r_fix   = neg_a_q ? -rem_q : rem_q;
  assign sel     = op_q[1] ? r_fix : q_fix;
  assign fix_res = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    word_d  = word_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d    = op;
          word_d  = word_op;
          neg_a_d = neg_a;
          neg_b_d = neg_b;
          rem_d   = '0;
          // Word dividends sit in the top half so the MSB-first shift is the same for both widths.
          dvd_d   = word_op ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
          dvs_d   = word_op ? {{(XLEN-32){1'b0}}, mag_b[31:0]} : mag_b;
          if (b_zero || ovf) begin
            res_d   = spec_res;
            state_d = DONE;
          end else begin
            cnt_d   = word_op ? CW'(31) : CW'(XLEN-1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
        dvd_d = {dvd_q[XLEN-2:0], ~trial[XLEN]};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        res_d   = fix_res;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      word_q  <= word_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed corner cases plus random ops against an arithmetic reference.
module tb_div_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  op;
  logic        word_op;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] res;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  div_seq #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .word_op(word_op), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sext32(input logic [63:0] v);
    int t;
    longint l;
    t = v[31:0];
    l = t;
    return l;
  endfunction

  function automatic logic is_special(input logic [63:0] av, input logic [63:0] bv,
                                      input logic [1:0] o, input logic w);
    logic dz, ov;
    dz = w ? (bv[31:0] == 32'd0) : (bv == 64'd0);
    ov = !o[0] && (w ? (av[31:0] == 32'h8000_0000 && bv[31:0] == 32'hFFFF_FFFF)
                     : (av == 64'h8000_0000_0000_0000 && bv == '1));
    return dz || ov;
  endfunction

  // RISC-V M semantics straight from the ISA rules, using native signed/unsigned arithmetic.
  function automatic logic [63:0] model(input logic [63:0] av, input logic [63:0] bv,
                                        input logic [1:0] o, input logic w);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, q, r, rv;
    sa = w ? sext32(av) : av;
    sb = w ? sext32(bv) : bv;
    ua = w ? {32'd0, av[31:0]} : av;
    ub = w ? {32'd0, bv[31:0]} : bv;
    if (!o[0]) begin
      if (sb == 0) begin
        q = '1; r = sa;
      end else if (sb == -1 && (w ? av[31:0] == 32'h8000_0000 : av == 64'h8000_0000_0000_0000)) begin
        q = sa; r = '0;
      end else begin
        sq = sa / sb; sr = sa % sb;
        q = sq; r = sr;
      end
    end else begin
      if (ub == 0) begin
        q = '1; r = ua;
      end else begin
        q = ua / ub; r = ua % ub;
      end
    end
    rv = o[1] ? r : q;
    return w ? sext32(rv) : rv;
  endfunction

  task automatic run(input string tag, input logic [63:0] av, input logic [63:0] bv,
                     input logic [1:0] o, input logic w, input int hold, input logic [63:0] exp);
    int lat;
    int exp_lat;
    logic [63:0] held;
    exp_lat = is_special(av, bv, o, w) ? 0 : (w ? 33 : 65);
    @(negedge clk);
    check({tag, "/in_ready"}, {63'd0, in_ready}, 64'd1);
    a = av; b = bv; op = o; word_op = w; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    op = 2'($urandom); word_op = 1'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/res"}, res, exp);
    held = res;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "/hold_valid"}, {62'd0, out_valid, in_ready}, 64'd2);
      check({tag, "/hold_res"}, res, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/drain"}, {62'd0, out_valid, busy}, 64'd0);
  endtask

  function automatic logic [63:0] pick(input logic w);
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = '1;
      2: v = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
      3: v = 64'($urandom_range(1, 20));
      4: v = {32'd0, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    logic seen;
    logic [63:0] ra, rb;
    logic [1:0]  ro;
    logic        rw;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; word_op = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    check("reset", {res[31:0], 29'd0, out_valid, busy, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    run("div_m7_2",   -64'sd7, 64'd2, 2'b00, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFD);
    run("rem_m7_2",   -64'sd7, 64'd2, 2'b10, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run("divu_by0",   64'd100, 64'd0, 2'b01, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run("remu_by0",   64'd100, 64'd0, 2'b11, 1'b0, 0, 64'd100);
    run("div_ovf",    64'h8000_0000_0000_0000, '1, 2'b00, 1'b0, 0, 64'h8000_0000_0000_0000);
    run("divw_ovf",   64'h8000_0000, 64'hFFFF_FFFF, 2'b00, 1'b1, 0, 64'hFFFF_FFFF_8000_0000);
    run("remw_ovf",   64'h8000_0000, 64'hFFFF_FFFF, 2'b10, 1'b1, 0, 64'd0);
    run("remuw",      64'h1_0000_0005, 64'd3, 2'b11, 1'b1, 0, 64'd2);
    run("divuw_sext", 64'hFFFF_FFFF, 64'd1, 2'b01, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    run("div_hold",   64'd1000, 64'd7, 2'b00, 1'b0, 5, 64'd142);

    // Flush ten cycles into CALC: result dropped, sequencer immediately free.
    @(negedge clk);
    a = 64'd1000; b = 64'd7; op = 2'b00; word_op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_calc", {61'd0, busy, in_ready, out_valid}, 64'd2);
    seen = 1'b0;
    repeat (70) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("flush_no_valid", {63'd0, seen}, 64'd0);
    check("flush_res_kept", res, 64'd142);
    run("divu_after_flush", 64'd9, 64'd3, 2'b01, 1'b0, 0, 64'd3);

    // Flush with a request in IDLE must not accept it.
    @(negedge clk);
    a = 64'd50; b = 64'd5; op = 2'b01; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle", {62'd0, busy, in_ready}, 64'd1);

    // Flush beats out_ready in DONE; res keeps its value.
    @(negedge clk);
    a = 64'd77; b = 64'd0; op = 2'b11; word_op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("flush_done_pre", {63'd0, out_valid}, 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done", {62'd0, out_valid, busy}, 64'd0);
    check("flush_done_res", res, 64'd77);

    // Asynchronous reset mid-CALC, sampled between clock edges.
    @(negedge clk);
    a = 64'd12345; b = 64'd17; op = 2'b00; word_op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", {res[31:0], 29'd0, out_valid, busy, in_ready}, 64'd1);
    check("async_rst_res", res, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom);
      rw = 1'($urandom);
      ra = pick(rw);
      rb = pick(rw);
      run($sformatf("rand%0d", i), ra, rb, ro, rw, $urandom_range(0, 2), model(ra, rb, ro, rw));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
